// File: rtl/rom_count_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : rom_count_sequencer
// Brief   : Count sequencer feeding a 4-bit ROM incrementer and publishing
//           counts over valid/ready, with run/stop/step/load and limit control.
// Revision: 1.0 - initial release
// ============================================================================
module rom_count_sequencer #(
  parameter int                 WIDTH    = 4,
  parameter logic [WIDTH-1:0]   WRAP_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             step,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] limit,
  input  logic             wrap_en,
  output logic [WIDTH-1:0] rom_addr,
  input  logic [WIDTH-1:0] rom_data,
  output logic [WIDTH-1:0] count,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             tc,
  output logic             done
);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_RUN  = 2'd1;
  localparam logic [1:0] c_STEP = 2'd2;
  localparam logic [1:0] c_DONE = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;
  logic             w_offer;
  logic             w_accept;
  logic             w_at_limit;

  assign w_offer    = (state_q == c_RUN) || (state_q == c_STEP);
  assign w_accept   = w_offer && out_ready;
  assign w_at_limit = (count_q == limit);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= c_IDLE;
      count_q <= WRAP_VAL;
      tc_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      tc_q    <= tc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    tc_d    = 1'b0;
    if (load) begin
      count_d = load_val;
      state_d = c_IDLE;
    end else if (stop) begin
      // A stop wins over a simultaneous accept: the offered value is kept.
      if (w_offer) begin
        state_d = c_IDLE;
      end
    end else begin
      case (state_q)
        c_IDLE: begin
          if (start) begin
            state_d = c_RUN;
          end else if (step) begin
            state_d = c_STEP;
          end
        end
        c_RUN, c_STEP: begin
          if (w_accept) begin
            if (state_q == c_STEP) begin
              state_d = c_IDLE;
            end
            if (w_at_limit) begin
              tc_d = 1'b1;
              if (wrap_en) begin
                count_d = WRAP_VAL;
              end else begin
                state_d = c_DONE;
              end
            end else begin
              count_d = rom_data;
            end
          end
        end
        default: begin
          if (start) begin
            count_d = WRAP_VAL;
            state_d = c_RUN;
          end
        end
      endcase
    end
  end

  always_comb begin
    rom_addr  = count_q;
    count     = count_q;
    out_valid = w_offer;
    tc        = tc_q;
    done      = (state_q == c_DONE);
  end

endmodule
`default_nettype wire

// File: tb/tb_rom_count_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_rom_count_sequencer
// Brief   : Scoreboard bench for rom_count_sequencer with a modelled ROM.
// Revision: 1.0 - initial release
// ============================================================================
module tb_rom_count_sequencer;

  logic       clk;
  logic       rst;
  logic       start, stop, step, load;
  logic [3:0] load_val, limit;
  logic       wrap_en;
  logic [3:0] rom_addr, rom_data, count;
  logic       out_valid, out_ready, tc, done;

  int         n_checks;
  int         n_fail;
  logic [3:0] exp_q[$];

  rom_count_sequencer #(.WIDTH(4), .WRAP_VAL(4'd0)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .stop      (stop),
    .step      (step),
    .load      (load),
    .load_val  (load_val),
    .limit     (limit),
    .wrap_en   (wrap_en),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .count     (count),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .tc        (tc),
    .done      (done)
  );

  // Incrementer ROM stand-in: data = addr + 1 mod 16
  assign rom_data = rom_addr + 4'd1;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Transfer monitor: every accepted count must match the next expected value
  always @(negedge clk) begin
    if (!rst) begin
      check_eq("rom_addr_eq_count", rom_addr, count);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check_eq("xfer_expected_pending", 0, 1);
        end else begin
          check_eq("xfer_value", count, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst       = 1'b1;
    start     = 1'b0;
    stop      = 1'b0;
    step      = 1'b0;
    load      = 1'b0;
    load_val  = 4'd0;
    limit     = 4'hF;
    wrap_en   = 1'b1;
    out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    check_eq("rst_count", count, 0);
    check_eq("rst_valid", out_valid, 0);
    check_eq("rst_tc", tc, 0);
    check_eq("rst_done", done, 0);

    // Full sweep 0..F with wrap at limit F
    for (int v = 0; v < 16; v++) exp_q.push_back(4'(v));
    out_ready = 1'b1;
    start     = 1'b1;
    tick();
    start = 1'b0;
    check_eq("s1_first_count", count, 0);
    for (int i = 2; i <= 17; i++) begin
      tick();
      check_eq("s1_count", count, (i - 1) & 15);
      check_eq("s1_tc", tc, (i == 17) ? 1 : 0);
    end
    out_ready = 1'b0;
    stop      = 1'b1;
    tick();
    stop = 1'b0;
    check_eq("s1_tc_width", tc, 0);
    check_eq("s1_stopped", out_valid, 0);
    check_eq("s1_queue_drained", exp_q.size(), 0);

    // Limit 5 without wrap: stop in DONE, then restart
    limit    = 4'd5;
    wrap_en  = 1'b0;
    load_val = 4'd0;
    load     = 1'b1;
    tick();
    load = 1'b0;
    for (int v = 0; v <= 5; v++) exp_q.push_back(4'(v));
    out_ready = 1'b1;
    start     = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i <= 5; i++) begin
      tick();
      check_eq("s2_tc", tc, (i == 5) ? 1 : 0);
      check_eq("s2_done", done, (i == 5) ? 1 : 0);
    end
    check_eq("s2_hold_count", count, 5);
    check_eq("s2_valid_low", out_valid, 0);
    tick();
    check_eq("s2_tc_once", tc, 0);
    check_eq("s2_done_hold", done, 1);
    check_eq("s2_count_hold", count, 5);
    out_ready = 1'b0;
    start     = 1'b1;
    tick();
    start = 1'b0;
    check_eq("s2_restart_count", count, 0);
    check_eq("s2_restart_valid", out_valid, 1);
    check_eq("s2_restart_done", done, 0);

    // Backpressure: ready 1,0,0,1
    exp_q.push_back(4'd0);
    exp_q.push_back(4'd1);
    out_ready = 1'b1; tick(); check_eq("bp_c1", count, 1);
    out_ready = 1'b0; tick(); check_eq("bp_c2", count, 1);
    tick();                   check_eq("bp_c3", count, 1);
    check_eq("bp_valid_stall", out_valid, 1);
    out_ready = 1'b1; tick(); check_eq("bp_c4", count, 2);
    out_ready = 1'b0;

    // Load beats stop and start, then a single step
    load_val = 4'hC;
    load     = 1'b1;
    start    = 1'b1;
    stop     = 1'b1;
    tick();
    load  = 1'b0;
    start = 1'b0;
    stop  = 1'b0;
    check_eq("ld_count", count, 12);
    check_eq("ld_valid", out_valid, 0);
    check_eq("ld_tc", tc, 0);
    exp_q.push_back(4'hC);
    step      = 1'b1;
    out_ready = 1'b1;
    tick();
    step = 1'b0;
    check_eq("step_valid", out_valid, 1);
    tick();
    check_eq("step_count", count, 13);
    check_eq("step_idle", out_valid, 0);
    tick();
    check_eq("step_stays_idle", out_valid, 0);
    check_eq("step_count_hold", count, 13);

    // Wrap at limit 3 starting from E: natural F->0 wrap gives no tc
    limit    = 4'd3;
    wrap_en  = 1'b1;
    load_val = 4'hE;
    load     = 1'b1;
    tick();
    load = 1'b0;
    exp_q.push_back(4'hE);
    exp_q.push_back(4'hF);
    for (int v = 0; v <= 3; v++) exp_q.push_back(4'(v));
    start = 1'b1;
    tick();
    start = 1'b0;
    check_eq("wr_first", count, 14);
    for (int i = 0; i <= 5; i++) begin
      tick();
      check_eq("wr_tc", tc, (i == 5) ? 1 : 0);
      if (i == 5) out_ready = 1'b0;
    end
    check_eq("wr_wrapval", count, 0);
    check_eq("wr_still_run", out_valid, 1);

    // Asynchronous reset mid-run at count 7
    load_val = 4'd7;
    load     = 1'b1;
    tick();
    load  = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check_eq("ar_pre_count", count, 7);
    check_eq("ar_pre_valid", out_valid, 1);
    #2;
    rst = 1'b1;
    #1;
    check_eq("ar_count", count, 0);
    check_eq("ar_valid", out_valid, 0);
    check_eq("ar_tc", tc, 0);
    check_eq("ar_done", done, 0);
    tick();
    rst       = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("ar_idle_valid", out_valid, 0);
      check_eq("ar_idle_count", count, 0);
    end
    check_eq("final_queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
